st7789_spi_rx: RTL and testbench

SPI slave receiver that sits at the far end of the LCD video SPI link and interprets the stream the way an ST7789 panel does. It turns spi_clk/spi_mosi/spi_dc/spi_csn into command bytes, window settings and addressed 16-bit pixel writes. Uses include loopback verification of the transmitter in simulation and on-board, and re-displaying the OLED image on another output such as a framebuffer.

---
 rtl/st7789_spi_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_st7789_spi_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st7789_spi_rx.sv
// st7789_spi_rx: SPI slave that decodes an ST7789-style command/data stream.
// It recovers command bytes, data bytes, CASET/RASET window settings and
// RAMWR pixel writes, and reports each pixel with its (x, y) position.
module st7789_spi_rx #(
    parameter int c_x_bits = 8,
    parameter int c_y_bits = 8,
    parameter int c_width  = 240,
    parameter int c_height = 240
) (
    input  logic                clk,
    input  logic                resn,
    input  logic                spi_clk,
    input  logic                spi_mosi,
    input  logic                spi_dc,
    input  logic                spi_csn,
    output logic                cmd_valid,
    output logic [7:0]          cmd,
    output logic                data_valid,
    output logic [7:0]          data,
    output logic                pixel_valid,
    output logic [c_x_bits-1:0] pixel_x,
    output logic [c_y_bits-1:0] pixel_y,
    output logic [15:0]         pixel_color
);

    localparam logic [c_x_bits-1:0] XE_DEF = c_x_bits'(c_width - 1);
    localparam logic [c_y_bits-1:0] YE_DEF = c_y_bits'(c_height - 1);
    // Reset value of each synchroniser: chip select idles high, the rest low.
    localparam logic [3:0] SYNC_RST = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR,
        ST_SKIP
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: two-stage synchroniser per SPI input.
    // Bit order: 0 = spi_clk, 1 = spi_mosi, 2 = spi_dc, 3 = spi_csn.
    // ------------------------------------------------------------------
    logic [3:0] spi_raw;
    logic [3:0] spi_sync;

    assign spi_raw = {spi_csn, spi_dc, spi_mosi, spi_clk};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            logic [1:0] sync_reg;
            // Two flip-flops bring the asynchronous SPI line into clk.
            always_ff @(posedge clk or negedge resn) begin
                if (!resn) begin
                    sync_reg <= {2{SYNC_RST[gi]}};
                end else begin
                    sync_reg <= {sync_reg[0], spi_raw[gi]};
                end
            end
            assign spi_sync[gi] = sync_reg[1];
        end
    endgenerate

    logic sclk_s, mosi_s, dc_s, csn_s;
    assign sclk_s = spi_sync[0];
    assign mosi_s = spi_sync[1];
    assign dc_s   = spi_sync[2];
    assign csn_s  = spi_sync[3];

    logic sclk_d_reg;
    logic sclk_rise;

    // Third stage on spi_clk only, used to detect the rising sample edge.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            sclk_d_reg <= 1'b0;
        end else begin
            sclk_d_reg <= sclk_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d_reg;

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_reg;
    logic [6:0] shift_reg;
    logic       dc_first_reg;
    logic       byte_ready_reg;
    logic [7:0] byte_val_reg;
    logic       byte_dc_reg;

    // Shift MOSI on each sample edge; csn high drops any partial byte.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 7'd0;
            dc_first_reg   <= 1'b0;
            byte_ready_reg <= 1'b0;
            byte_val_reg   <= 8'd0;
            byte_dc_reg    <= 1'b0;
        end else begin
            byte_ready_reg <= 1'b0;
            if (csn_s) begin
                bit_cnt_reg <= 3'd0;
                shift_reg   <= 7'd0;
            end else if (sclk_rise) begin
                shift_reg   <= {shift_reg[5:0], mosi_s};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                // D/C belongs to the byte as seen at its first bit.
                if (bit_cnt_reg == 3'd0) begin
                    dc_first_reg <= dc_s;
                end
                if (bit_cnt_reg == 3'd7) begin
                    byte_ready_reg <= 1'b1;
                    byte_val_reg   <= {shift_reg, mosi_s};
                    byte_dc_reg    <= dc_first_reg;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command / parameter decoder
    // ------------------------------------------------------------------
    state_t              state_reg;
    logic [1:0]          param_idx_reg;
    logic [7:0]          param_hi_reg;
    logic                hi_flag_reg;
    logic [7:0]          hi_byte_reg;
    logic [c_x_bits-1:0] xs_reg, xe_reg, ptr_x_reg;
    logic [c_y_bits-1:0] ys_reg, ye_reg, ptr_y_reg;

    logic                cmd_valid_reg, data_valid_reg, pixel_valid_reg;
    logic [7:0]          cmd_reg, data_reg;
    logic [c_x_bits-1:0] pixel_x_reg;
    logic [c_y_bits-1:0] pixel_y_reg;
    logic [15:0]         pixel_color_reg;

    // Interpret each completed byte; outputs are registered with their pulse.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_reg       <= ST_IDLE;
            param_idx_reg   <= 2'd0;
            param_hi_reg    <= 8'd0;
            hi_flag_reg     <= 1'b0;
            hi_byte_reg     <= 8'd0;
            xs_reg          <= '0;
            xe_reg          <= XE_DEF;
            ys_reg          <= '0;
            ye_reg          <= YE_DEF;
            ptr_x_reg       <= '0;
            ptr_y_reg       <= '0;
            cmd_valid_reg   <= 1'b0;
            data_valid_reg  <= 1'b0;
            pixel_valid_reg <= 1'b0;
            cmd_reg         <= 8'd0;
            data_reg        <= 8'd0;
            pixel_x_reg     <= '0;
            pixel_y_reg     <= '0;
            pixel_color_reg <= 16'd0;
        end else begin
            cmd_valid_reg   <= 1'b0;
            data_valid_reg  <= 1'b0;
            pixel_valid_reg <= 1'b0;
            if (byte_ready_reg && !byte_dc_reg) begin
                cmd_reg       <= byte_val_reg;
                cmd_valid_reg <= 1'b1;
                param_idx_reg <= 2'd0;
                hi_flag_reg   <= 1'b0;
                case (byte_val_reg)
                    8'h2A: state_reg <= ST_CASET;
                    8'h2B: state_reg <= ST_RASET;
                    8'h2C: begin
                        state_reg <= ST_RAMWR;
                        ptr_x_reg <= xs_reg;
                        ptr_y_reg <= ys_reg;
                    end
                    8'h01: begin
                        state_reg <= ST_IDLE;
                        xs_reg    <= '0;
                        xe_reg    <= XE_DEF;
                        ys_reg    <= '0;
                        ye_reg    <= YE_DEF;
                    end
                    default: state_reg <= ST_SKIP;
                endcase
            end else if (byte_ready_reg) begin
                data_reg       <= byte_val_reg;
                data_valid_reg <= 1'b1;
                case (state_reg)
                    ST_CASET, ST_RASET: begin
                        param_idx_reg <= param_idx_reg + 2'd1;
                        if (!param_idx_reg[0]) begin
                            param_hi_reg <= byte_val_reg;
                        end else if (state_reg == ST_CASET) begin
                            if (param_idx_reg == 2'd1) begin
                                xs_reg <= c_x_bits'({param_hi_reg, byte_val_reg});
                            end else begin
                                xe_reg    <= c_x_bits'({param_hi_reg, byte_val_reg});
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            if (param_idx_reg == 2'd1) begin
                                ys_reg <= c_y_bits'({param_hi_reg, byte_val_reg});
                            end else begin
                                ye_reg    <= c_y_bits'({param_hi_reg, byte_val_reg});
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                    ST_RAMWR: begin
                        if (!hi_flag_reg) begin
                            hi_byte_reg <= byte_val_reg;
                            hi_flag_reg <= 1'b1;
                        end else begin
                            hi_flag_reg     <= 1'b0;
                            pixel_color_reg <= {hi_byte_reg, byte_val_reg};
                            pixel_x_reg     <= ptr_x_reg;
                            pixel_y_reg     <= ptr_y_reg;
                            pixel_valid_reg <= 1'b1;
                            // Raster advance inside the window, wrapping the frame.
                            if (ptr_x_reg == xe_reg) begin
                                ptr_x_reg <= xs_reg;
                                if (ptr_y_reg == ye_reg) begin
                                    ptr_y_reg <= ys_reg;
                                end else begin
                                    ptr_y_reg <= ptr_y_reg + 1'b1;
                                end
                            end else begin
                                ptr_x_reg <= ptr_x_reg + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (csn_s) begin
                // Deselect between bytes discards a half-received pixel.
                hi_flag_reg <= 1'b0;
            end
        end
    end

    assign cmd_valid   = cmd_valid_reg;
    assign cmd         = cmd_reg;
    assign data_valid  = data_valid_reg;
    assign data        = data_reg;
    assign pixel_valid = pixel_valid_reg;
    assign pixel_x     = pixel_x_reg;
    assign pixel_y     = pixel_y_reg;
    assign pixel_color = pixel_color_reg;

endmodule

// File: tb/tb_st7789_spi_rx.sv
// Testbench for st7789_spi_rx: directed SPI transactions feed expectation
// queues; an independent monitor checks every output pulse against them.
module tb_st7789_spi_rx;

    logic       clk = 1'b0;
    logic       resn = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_dc = 1'b0;
    logic       spi_csn = 1'b1;
    logic       cmd_valid, data_valid, pixel_valid;
    logic [7:0] cmd, data;
    logic [7:0] pixel_x, pixel_y;
    logic [15:0] pixel_color;

    st7789_spi_rx #(
        .c_x_bits(8),
        .c_y_bits(8),
        .c_width (240),
        .c_height(240)
    ) dut (
        .clk        (clk),
        .resn       (resn),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_dc     (spi_dc),
        .spi_csn    (spi_csn),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .data_valid (data_valid),
        .data       (data),
        .pixel_valid(pixel_valid),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_color(pixel_color)
    );

    // 125 MHz system clock
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] v;
        int         t;
    } byte_exp_t;

    typedef struct {
        logic [15:0] c;
        logic [7:0]  x;
        logic [7:0]  y;
    } pix_exp_t;

    byte_exp_t cmd_q[$];
    byte_exp_t data_q[$];
    pix_exp_t  pix_q[$];

    int   checks = 0;
    int   errors = 0;
    logic end_check = 1'b0;
    logic end_done = 1'b0;

    byte_exp_t mon_b;
    pix_exp_t  mon_p;

    // Monitor: every pulse pops the matching queue; reset and drain checks too.
    always @(negedge clk) begin
        if (!resn) begin
            checks++;
            if ({cmd_valid, data_valid, pixel_valid, cmd, data, pixel_x, pixel_y, pixel_color} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: cmd_v=%b data_v=%b pix_v=%b cmd=%h data=%h x=%0d y=%0d color=%h, required all zero",
                         cmd_valid, data_valid, pixel_valid, cmd, data, pixel_x, pixel_y, pixel_color);
            end
        end else begin
            if (cmd_valid) begin
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected: cmd=%h at cycle %0d, required no cmd_valid", cmd, cyc);
                end else begin
                    mon_b = cmd_q.pop_front();
                    if (cmd !== mon_b.v || cyc != mon_b.t) begin
                        errors++;
                        $display("FAIL cmd: got %h at cycle %0d, required %h at cycle %0d", cmd, cyc, mon_b.v, mon_b.t);
                    end else begin
                        $display("cmd   %h at cycle %0d ok", cmd, cyc);
                    end
                end
            end
            if (data_valid) begin
                checks++;
                if (data_q.size() == 0) begin
                    errors++;
                    $display("FAIL data_unexpected: data=%h at cycle %0d, required no data_valid", data, cyc);
                end else begin
                    mon_b = data_q.pop_front();
                    if (data !== mon_b.v || cyc != mon_b.t) begin
                        errors++;
                        $display("FAIL data: got %h at cycle %0d, required %h at cycle %0d", data, cyc, mon_b.v, mon_b.t);
                    end else begin
                        $display("data  %h at cycle %0d ok", data, cyc);
                    end
                end
            end
            if (pixel_valid) begin
                checks++;
                if (pix_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_unexpected: color=%h at (%0d,%0d), required no pixel_valid", pixel_color, pixel_x, pixel_y);
                end else begin
                    mon_p = pix_q.pop_front();
                    if (pixel_color !== mon_p.c || pixel_x !== mon_p.x || pixel_y !== mon_p.y || data_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL pixel: got %h at (%0d,%0d) data_valid=%b, required %h at (%0d,%0d) data_valid=1",
                                 pixel_color, pixel_x, pixel_y, data_valid, mon_p.c, mon_p.x, mon_p.y);
                    end else begin
                        $display("pixel %h at (%0d,%0d) ok", pixel_color, pixel_x, pixel_y);
                    end
                end
            end
        end
        if (end_check && !end_done) begin
            end_done = 1'b1;
            checks++;
            if (cmd_q.size() != 0) begin
                errors++;
                $display("FAIL cmd_missing: %0d commands outstanding, required 0", cmd_q.size());
            end
            checks++;
            if (data_q.size() != 0) begin
                errors++;
                $display("FAIL data_missing: %0d data bytes outstanding, required 0", data_q.size());
            end
            checks++;
            if (pix_q.size() != 0) begin
                errors++;
                $display("FAIL pixel_missing: %0d pixels outstanding, required 0", pix_q.size());
            end
        end
    end

    // One SPI bit, mode 0: data set with spi_clk low, 2 clk low, 2 clk high.
    task automatic spi_bit(input logic dc, input logic b, output int t_pulse);
        spi_mosi = b;
        spi_dc   = dc;
        repeat (2) @(negedge clk);
        spi_clk = 1'b1;
        t_pulse = cyc + 4;
        repeat (2) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        int        t;
        byte_exp_t e;
        for (int i = 7; i >= 0; i--) spi_bit(dc, b[i], t);
        e.v = b;
        e.t = t;
        if (dc) data_q.push_back(e);
        else    cmd_q.push_back(e);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        int t;
        for (int i = 7; i > 7 - n; i--) spi_bit(1'b1, b[i], t);
    endtask

    task automatic push_pix(input logic [15:0] c, input logic [7:0] x, input logic [7:0] y);
        pix_exp_t p;
        p.c = c;
        p.x = x;
        p.y = y;
        pix_q.push_back(p);
    endtask

    task automatic send_pixel(input logic [15:0] c);
        send_byte(1'b1, c[15:8]);
        send_byte(1'b1, c[7:0]);
    endtask

    task automatic csn_low();
        spi_csn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic csn_high();
        repeat (3) @(negedge clk);
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Expected coordinates for the 7-pixel stream in the 10..12 x 5..6 window
    int win_x[7] = '{10, 11, 12, 10, 11, 12, 10};
    int win_y[7] = '{5, 5, 5, 6, 6, 6, 5};

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at 1 ms, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held while the SPI lines toggle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            spi_clk  = i[0];
            spi_mosi = i[1];
            spi_csn  = i[2];
            spi_dc   = i[3];
        end
        @(negedge clk);
        spi_clk = 1'b0;
        spi_csn = 1'b1;
        resn    = 1'b1;
        repeat (4) @(negedge clk);

        // First pixel after reset lands at (0,0)
        csn_low();
        send_byte(1'b0, 8'h2C);
        push_pix(16'h0001, 8'd0, 8'd0);
        send_pixel(16'h0001);
        csn_high();

        // Window 10..12 x 5..6, 7 pixels, deselect between pixels 3 and 4
        csn_low();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0C);
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 7; i++) begin
            push_pix(16'h1234 + 16'(i), 8'(win_x[i]), 8'(win_y[i]));
            send_pixel(16'h1234 + 16'(i));
            if (i == 2) begin
                csn_high();
                csn_low();
            end
        end
        csn_high();

        // Unknown command followed by a data byte: no pixel
        csn_low();
        send_byte(1'b0, 8'h3A);
        send_byte(1'b1, 8'h55);
        csn_high();

        // Abort after a whole high byte
        csn_low();
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hAB);
        csn_high();
        csn_low();
        push_pix(16'hF800, 8'd10, 8'd5);
        send_pixel(16'hF800);
        csn_high();

        // Abort after a high byte plus 5 stray bits
        csn_low();
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hAB);
        send_partial(8'hFF, 5);
        csn_high();
        csn_low();
        push_pix(16'hF800, 8'd10, 8'd5);
        send_pixel(16'hF800);
        csn_high();

        // Narrow window, SWRESET, then 241 pixels over the default window
        csn_low();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h03);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h04);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 241; i++) begin
            push_pix(16'(i), 8'(i % 240), 8'(i / 240));
            send_pixel(16'(i));
        end
        csn_high();

        repeat (20) @(negedge clk);
        @(posedge clk);
        end_check = 1'b1;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
